// File: rtl/uart_tx_fifo.sv
// 16550-style UART transmitter: a TX FIFO feeding a programmable-frame serializer.
// Frame config is latched at every FIFO pop, so LCR writes only affect the next character.
module uart_tx_fifo #(
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 16,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MAX_DATA_BITS-1:0]         wr_data,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic                             fifo_clr,
    input  logic [3:0]                       data_bits,
    input  logic                             parity_en,
    input  logic                             parity_even,
    input  logic                             parity_stick,
    input  logic [1:0]                       stop_bits,
    input  logic                             break_ctrl,
    input  logic                             tick,
    output logic                             txd,
    output logic                             enable_baud,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             thre,
    output logic                             temt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(2 * OVERSAMPLE);

    localparam logic [LW-1:0] DEPTH_L    = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0] BIT_M1     = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP15_M1  = TW'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] STOP2_M1   = TW'(2 * OVERSAMPLE - 1);
    localparam logic [3:0]    MAX_BITS_L = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_next;

    // FIFO
    logic [MAX_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [LW-1:0]            level, level_next;
    logic                     push, pop;
    logic [MAX_DATA_BITS-1:0] head, head_mask;

    // Serializer
    logic [3:0]               clamp_bits;
    logic                     head_parity;
    logic [MAX_DATA_BITS-1:0] shifter;
    logic [TW-1:0]            tick_cnt, stop_m1, bit_len_m1;
    logic [3:0]               bit_cnt, cfg_last;
    logic                     cfg_par_en, par_bit;
    logic [1:0]               cfg_stop;
    logic                     bit_end, line_bit, break_q;
    logic                     thre_q, temt_q;

    assign wr_ready   = (level != DEPTH_L);
    assign push       = wr_valid && wr_ready && !fifo_clr;
    assign head       = mem[rd_ptr];
    assign fifo_level = level;
    assign thre       = thre_q;
    assign temt       = temt_q;

    // NOTE: the storage array is deliberately not reset; entries outside rd_ptr..wr_ptr are never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_comb begin
        level_next = level;
        if (fifo_clr)
            level_next = '0;
        else if (push && !pop)
            level_next = level + 1'b1;
        else if (pop && !push)
            level_next = level - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_next;
            if (fifo_clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        clamp_bits = data_bits;
        if (data_bits < 4'd5)
            clamp_bits = 4'd5;
        else if (data_bits > MAX_BITS_L)
            clamp_bits = MAX_BITS_L;
        for (int i = 0; i < MAX_DATA_BITS; i++)
            head_mask[i] = (i < int'(clamp_bits));
        head_parity = parity_stick ? ~parity_even
                                   : (^(head & head_mask)) ^ ~parity_even;
    end

    always_comb begin
        case (cfg_stop)
            2'b00:   stop_m1 = BIT_M1;
            2'b01:   stop_m1 = STOP15_M1;
            default: stop_m1 = STOP2_M1;
        endcase
        bit_len_m1 = (state == S_STOP) ? stop_m1 : BIT_M1;
        bit_end    = tick && (tick_cnt == bit_len_m1);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // FSM: next state; a pending fifo_clr suppresses the pop so cleared characters never start
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (level != '0 && !fifo_clr) begin
                    pop        = 1'b1;
                    state_next = S_START;
                end
            end
            S_START:  if (bit_end) state_next = S_DATA;
            S_DATA: begin
                if (bit_end && bit_cnt == cfg_last)
                    state_next = cfg_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_end) state_next = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    if (level != '0 && !fifo_clr) begin
                        pop        = 1'b1;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Serializer datapath and registered status
    always_ff @(posedge clk) begin
        if (!rst) begin
            shifter    <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            cfg_last   <= 4'd7;
            cfg_par_en <= 1'b0;
            cfg_stop   <= 2'b00;
            par_bit    <= 1'b0;
            break_q    <= 1'b0;
            thre_q     <= 1'b1;
            temt_q     <= 1'b1;
        end else begin
            break_q <= break_ctrl;
            thre_q  <= (level_next == '0);
            temt_q  <= (level_next == '0) && (state_next == S_IDLE);
            if (pop) begin
                shifter    <= head;
                cfg_last   <= clamp_bits - 4'd1;
                cfg_par_en <= parity_en;
                cfg_stop   <= stop_bits;
                par_bit    <= head_parity;
                tick_cnt   <= '0;
                bit_cnt    <= '0;
            end else if (tick && state != S_IDLE) begin
                if (bit_end) begin
                    tick_cnt <= '0;
                    if (state == S_DATA) begin
                        shifter <= shifter >> 1;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    // FSM: outputs; break is applied through a register so txd returns the cycle after release
    always_comb begin
        enable_baud = (state != S_IDLE);
        case (state)
            S_START:  line_bit = 1'b0;
            S_DATA:   line_bit = shifter[0];
            S_PARITY: line_bit = par_bit;
            default:  line_bit = 1'b1;
        endcase
        txd = line_bit && !break_q;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based frame model predicts txd at every
// counted tick; directed scenarios plus randomized frames exercise FIFO, status and break.
module tb_uart_tx_fifo;

    localparam int MAXB  = 9;
    localparam int DEPTH = 16;
    localparam int OVS   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [MAXB-1:0] wr_data = '0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic            fifo_clr = 1'b0;
    logic [3:0]      data_bits = 4'd8;
    logic            parity_en = 1'b0;
    logic            parity_even = 1'b0;
    logic            parity_stick = 1'b0;
    logic [1:0]      stop_bits = 2'b00;
    logic            break_ctrl = 1'b0;
    logic            tick = 1'b0;
    logic            txd;
    logic            enable_baud;
    logic [4:0]      fifo_level;
    logic            thre;
    logic            temt;

    uart_tx_fifo #(.MAX_DATA_BITS(MAXB), .FIFO_DEPTH(DEPTH), .OVERSAMPLE(OVS)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .fifo_clr     (fifo_clr),
        .data_bits    (data_bits),
        .parity_en    (parity_en),
        .parity_even  (parity_even),
        .parity_stick (parity_stick),
        .stop_bits    (stop_bits),
        .break_ctrl   (break_ctrl),
        .tick         (tick),
        .txd          (txd),
        .enable_baud  (enable_baud),
        .fifo_level   (fifo_level),
        .thre         (thre),
        .temt         (temt)
    );

    always #5 clk = ~clk;

    // Baud strobe: one clk wide, every 4 clocks
    int tphase = 0;
    always @(posedge clk) begin
        #1;
        tphase = (tphase + 1) % 4;
        tick   = (tphase == 0);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [MAXB-1:0] d;
        int              nb;
        bit              pen;
        bit              peven;
        bit              pstick;
        logic [1:0]      stop;
    } frame_t;

    frame_t pend[$];   // characters queued in the FIFO, as the model sees them
    bit     exp_q[$];  // expected txd value for each remaining tick of the current frame

    bit in_stream = 0;
    bit gap_seen  = 0;
    bit end_chk   = 0;
    bit brk_edge  = 0;
    bit avail;
    bit exp_bit;

    function automatic void expand(input frame_t f);
        int ones = 0;
        int stop_ticks;
        bit p;
        for (int t = 0; t < OVS; t++) exp_q.push_back(1'b0);
        for (int i = 0; i < f.nb; i++) begin
            ones += int'(f.d[i]);
            for (int t = 0; t < OVS; t++) exp_q.push_back(f.d[i]);
        end
        if (f.pen) begin
            if (f.pstick)         p = !f.peven;
            else if (ones % 2)    p = f.peven;
            else                  p = !f.peven;
            for (int t = 0; t < OVS; t++) exp_q.push_back(p);
        end
        stop_ticks = (f.stop == 2'b00) ? OVS : (f.stop == 2'b01) ? (3 * OVS / 2) : (2 * OVS);
        for (int t = 0; t < stop_ticks; t++) exp_q.push_back(1'b1);
    endfunction

    always @(posedge clk) brk_edge <= break_ctrl;

    // Tick-level monitor: every counted tick must carry the next modelled line bit
    always @(negedge clk) begin
        if (rst) begin
            if (brk_edge) check("break_txd", txd, 0);
            if (tick && enable_baud) begin
                if (exp_q.size() == 0 && pend.size() > 0) expand(pend.pop_front());
                avail = (exp_q.size() > 0);
                check("frame_expected", avail, 1);
                if (avail) begin
                    exp_bit = exp_q.pop_front();
                    if (!brk_edge) check("txd_bit", txd, exp_bit);
                    in_stream = 1;
                    if (exp_q.size() == 0 && pend.size() == 0) begin
                        end_chk   = 1;
                        in_stream = 0;
                    end
                end
            end else if (in_stream && !enable_baud) begin
                gap_seen = 1;
            end
        end
    end

    // One cycle after the final stop tick the serializer must be idle
    always @(posedge clk) begin
        if (end_chk) begin
            #1;
            check("end_enable_baud", enable_baud, 0);
            check("end_temt", temt, 1);
            end_chk = 0;
        end
    end

    task automatic push(input logic [MAXB-1:0] d);
        frame_t f;
        bit     accept;
        f.d      = d;
        f.nb     = (data_bits < 4'd5) ? 5 : (int'(data_bits) > MAXB) ? MAXB : int'(data_bits);
        f.pen    = parity_en;
        f.peven  = parity_even;
        f.pstick = parity_stick;
        f.stop   = stop_bits;
        accept   = (pend.size() < DEPTH);
        wr_data  = d;
        wr_valid = 1'b1;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (accept) pend.push_back(f);
    endtask

    task automatic wait_stream(input int budget);
        int n = 0;
        while (!in_stream && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stream_start_timeout", (n < budget), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(temt && !enable_baud && exp_q.size() == 0 && pend.size() == 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", (n < budget), 1);
        check("idle_txd", txd, 1);
        check("idle_thre", thre, 1);
        check("idle_level", fifo_level, 0);
        check("no_gap", gap_seen, 0);
        gap_seen = 0;
    endtask

    task automatic set_cfg(input logic [3:0] nb, input bit pen, input bit pev,
                           input bit pst, input logic [1:0] sb);
        data_bits    = nb;
        parity_en    = pen;
        parity_even  = pev;
        parity_stick = pst;
        stop_bits    = sb;
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd, 1);
        check("rst_enable_baud", enable_baud, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_thre", thre, 1);
        check("rst_temt", temt, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1 single character
        set_cfg(4'd8, 0, 0, 0, 2'b00);
        push(9'h0A5);
        wait_idle(2000);

        // 7E2, then stick parity with parity_even=1
        set_cfg(4'd7, 1, 1, 0, 2'b10);
        push(9'h003);
        wait_idle(2000);
        set_cfg(4'd7, 1, 1, 1, 2'b10);
        push(9'h003);
        wait_idle(2000);

        // Fill the FIFO behind a busy serializer; the 17th push is dropped
        set_cfg(4'd8, 0, 0, 0, 2'b00);
        push(9'($urandom_range(0, 255)));
        wait_stream(200);
        for (int i = 0; i < DEPTH; i++) push(9'($urandom_range(0, 255)));
        check("full_level", fifo_level, DEPTH);
        check("full_wr_ready", wr_ready, 0);
        check("full_thre", thre, 0);
        check("full_temt", temt, 0);
        push(9'($urandom_range(0, 255)));
        check("drop_level", fifo_level, DEPTH);
        wait_idle(12000);

        // 1.5 stop bits, break asserted mid-data
        set_cfg(4'd8, 0, 0, 0, 2'b01);
        push(9'($urandom_range(0, 255)));
        push(9'($urandom_range(0, 255)));
        wait_stream(200);
        repeat (90) @(posedge clk);
        #1;
        break_ctrl = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        break_ctrl = 1'b0;
        wait_idle(3000);

        // fifo_clr during byte 1, with a same-cycle push that must be discarded
        set_cfg(4'd8, 0, 0, 0, 2'b00);
        for (int i = 0; i < 4; i++) push(9'($urandom_range(0, 255)));
        wait_stream(200);
        repeat (40) @(posedge clk);
        #1;
        fifo_clr = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 9'h155;
        @(posedge clk);
        #1;
        fifo_clr = 1'b0;
        wr_valid = 1'b0;
        pend.delete();
        check("clr_level", fifo_level, 0);
        check("clr_thre", thre, 1);
        check("clr_temt", temt, 0);
        check("clr_enable_baud", enable_baud, 1);
        wait_idle(2000);

        // Reset mid-DATA
        for (int i = 0; i < 3; i++) push(9'($urandom_range(0, 255)));
        wait_stream(200);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_txd", txd, 1);
        check("midrst_enable_baud", enable_baud, 0);
        check("midrst_level", fifo_level, 0);
        check("midrst_temt", temt, 1);
        check("midrst_wr_ready", wr_ready, 1);
        exp_q.delete();
        pend.delete();
        in_stream = 0;
        end_chk   = 0;
        rst = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        wait_idle(100);

        // Randomized frame formats, including out-of-range data_bits
        for (int r = 0; r < 8; r++) begin
            set_cfg(4'($urandom_range(3, 11)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                push(9'($urandom_range(0, 511)));
            wait_idle(3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
